// File: rtl/arith_decode_pkg.sv
// rtl/arith_decode_pkg.sv - shared constants and types for the arith/decode slice
package arith_decode_pkg;

    localparam int WIDTH_DEFAULT = 8;

    // Unsigned magnitude compare result; exactly one field is set after a capture
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_t;

endpackage

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - combinational ripple-carry adder with carry-in and carry-out
module ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            // Full adder cell; each carry ripples into the next bit position
            assign S[i]       = A[i] ^ B[i] ^ carry[i];
            assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign Cout = carry[WIDTH];

endmodule

// File: rtl/arith_decode_unit.sv
// rtl/arith_decode_unit.sv - registered add, compare and one-hot decode slice
module arith_decode_unit
    import arith_decode_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     clr,
    input  logic                     load,
    input  logic [WIDTH-1:0]         A,
    input  logic [WIDTH-1:0]         B,
    input  logic                     Cin,
    input  logic [$clog2(WIDTH)-1:0] DI,
    input  logic                     en,
    output logic [WIDTH-1:0]         S,
    output logic                     Cout,
    output logic                     AltB,
    output logic                     AeqB,
    output logic                     AgtB,
    output logic [WIDTH-1:0]         D
);

    localparam int SELW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic             carry_out;
    cmp_t             cmp;
    logic [WIDTH-1:0] dec;

    ripple_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (sum),
        .Cout (carry_out)
    );

    // Unsigned magnitude compare of the raw operands
    always_comb begin
        cmp    = '0;
        cmp.lt = (A < B);
        cmp.eq = (A == B);
        cmp.gt = (A > B);
    end

    // One-hot decode of the select index, gated to all-zero when disabled
    always_comb begin
        dec = '0;
        if (en) begin
            dec[DI] = 1'b1;
        end
    end

    // Output register bank: cleared asynchronously, captured together on load
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            S    <= '0;
            Cout <= 1'b0;
            AltB <= 1'b0;
            AeqB <= 1'b0;
            AgtB <= 1'b0;
            D    <= '0;
        end else if (load) begin
            S    <= sum;
            Cout <= carry_out;
            AltB <= cmp.lt;
            AeqB <= cmp.eq;
            AgtB <= cmp.gt;
            D    <= dec;
        end
    end

    // Select width is tied to WIDTH; this documents the relationship for readers
    if (SELW < 1) begin : g_width_check
        $error("arith_decode_unit: WIDTH must be at least 2");
    end

endmodule

// File: tb/tb_arith_decode_unit.sv
// tb/tb_arith_decode_unit.sv - directed self-checking bench for arith_decode_unit
module tb_arith_decode_unit;

    localparam int WIDTH = 8;
    localparam int SELW  = 3;

    logic             clock;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [SELW-1:0]  DI;
    logic             en;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             AltB;
    logic             AeqB;
    logic             AgtB;
    logic [WIDTH-1:0] D;

    int tests_run;
    int tests_failed;

    arith_decode_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .clock (clock),
        .clr   (clr),
        .load  (load),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .DI    (DI),
        .en    (en),
        .S     (S),
        .Cout  (Cout),
        .AltB  (AltB),
        .AeqB  (AeqB),
        .AgtB  (AgtB),
        .D     (D)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] exp_s, input logic exp_cout,
                             input logic exp_lt, input logic exp_eq, input logic exp_gt,
                             input logic [7:0] exp_d);
        check({tag, ".S"},    32'(S),    32'(exp_s));
        check({tag, ".Cout"}, 32'(Cout), 32'(exp_cout));
        check({tag, ".AltB"}, 32'(AltB), 32'(exp_lt));
        check({tag, ".AeqB"}, 32'(AeqB), 32'(exp_eq));
        check({tag, ".AgtB"}, 32'(AgtB), 32'(exp_gt));
        check({tag, ".D"},    32'(D),    32'(exp_d));
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [2:0] di, input logic e, input logic ld);
        A    = a;
        B    = b;
        Cin  = c;
        DI   = di;
        en   = e;
        load = ld;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clr = 1'b0;
        drive(8'hA5, 8'h3C, 1'b1, 3'd6, 1'b1, 1'b1);

        // Reset with load high and nonzero inputs
        #2 clr = 1'b1;
        #1;
        check_all("reset_async", 8'h00, 0, 0, 0, 0, 8'h00);
        tick();
        check_all("reset_edge1", 8'h00, 0, 0, 0, 0, 8'h00);
        tick();
        check_all("reset_edge2", 8'h00, 0, 0, 0, 0, 8'h00);
        clr = 1'b0;

        // Basic capture
        drive(8'b10001000, 8'b00001111, 1'b0, 3'b111, 1'b1, 1'b1);
        tick();
        check_all("basic", 8'b10010111, 0, 0, 0, 1, 8'b10000000);

        // Overflow with carry-in
        drive(8'hFF, 8'h00, 1'b1, 3'b111, 1'b1, 1'b1);
        tick();
        check_all("ovf_ff", 8'h00, 1, 0, 0, 1, 8'b10000000);
        drive(8'h7F, 8'h80, 1'b1, 3'b000, 1'b1, 1'b1);
        tick();
        check_all("ovf_7f", 8'h00, 1, 1, 0, 0, 8'b00000001);

        // Maximum sum: FF + FF + 1 = 0x1FF
        drive(8'hFF, 8'hFF, 1'b1, 3'b100, 1'b1, 1'b1);
        tick();
        check_all("max_sum", 8'hFF, 1, 0, 1, 0, 8'b00010000);

        // Equal operands, decoder disabled then enabled
        drive(8'h55, 8'h55, 1'b0, 3'b011, 1'b0, 1'b1);
        tick();
        check_all("eq_en0", 8'hAA, 0, 0, 1, 0, 8'h00);
        drive(8'h55, 8'h55, 1'b0, 3'b011, 1'b1, 1'b1);
        tick();
        check_all("eq_en1", 8'hAA, 0, 0, 1, 0, 8'b00001000);

        // Hold: capture, then change everything with load low
        drive(8'h10, 8'h20, 1'b1, 3'd5, 1'b1, 1'b1);
        tick();
        check_all("hold_cap", 8'h31, 0, 1, 0, 0, 8'b00100000);
        drive(8'hF0, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("hold", 8'h31, 0, 1, 0, 0, 8'b00100000);
        end
        load = 1'b1;
        #1;
        check_all("hold_pre_edge", 8'h31, 0, 1, 0, 0, 8'b00100000);
        tick();
        check_all("hold_release", 8'hF1, 0, 0, 0, 1, 8'b00000001);

        // Mid-operation reset pulsed between edges
        @(negedge clock);
        clr = 1'b1;
        #1;
        check_all("mid_clr_async", 8'h00, 0, 0, 0, 0, 8'h00);
        tick();
        check_all("mid_clr_edge", 8'h00, 0, 0, 0, 0, 8'h00);
        @(negedge clock);
        clr  = 1'b0;
        load = 1'b0;
        tick();
        check_all("after_clr_noload", 8'h00, 0, 0, 0, 0, 8'h00);
        load = 1'b1;
        tick();
        check_all("after_clr_load", 8'hF1, 0, 0, 0, 1, 8'b00000001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arith_decode_unit.md
Name: arith_decode_unit

Overview:
- Registered datapath slice that bundles three width-parameterised combinational functions: ripple-carry add with carry-in/out, unsigned magnitude compare, and one-hot decode with enable.
- All results are captured into output registers on a load strobe, giving a clean one-cycle-latency interface to the surrounding datapath and control FSMs.

Parameters:
- WIDTH, 8, operand/sum width and number of decoder outputs; must be a power of two and at least 2.
- SELW, $clog2(WIDTH), decoder select width; derived, not overridden.

Ports:
- clock, input, 1, rising-edge clock.
- clr, input, 1, asynchronous active-high reset.
- load, input, 1, capture strobe; when high, all output registers update on the rising edge.
- A, input, WIDTH, operand A (unsigned).
- B, input, WIDTH, operand B (unsigned).
- Cin, input, 1, adder carry-in.
- DI, input, SELW, decoder select index.
- en, input, 1, decoder enable.
- S, output, WIDTH, registered sum A+B+Cin (low WIDTH bits).
- Cout, output, 1, registered carry-out of the sum.
- AltB, output, 1, registered A<B.
- AeqB, output, 1, registered A==B.
- AgtB, output, 1, registered A>B.
- D, output, WIDTH, registered one-hot decode of DI.

Behaviour:
- Reset: clr high forces S=0, Cout=0, AltB=0, AeqB=0, AgtB=0 and D=0 immediately, independent of clock. These values hold while clr is high, even if load is high.
- Capture: on a rising clock with clr low and load high, every output register takes the combinational result of the current inputs. Latency is exactly 1 cycle.
- With load low, all outputs hold their values. There is no partial update.
- Adder: {Cout,S} = A + B + Cin, computed at WIDTH+1 bits, unsigned. Wrap-around is the natural WIDTH-bit modulo; Cout reports the overflow.
- Compare: unsigned compare. Exactly one of AltB/AeqB/AgtB is 1 after any capture. All three are 0 only in the reset state.
- Decode with en=1: D[DI]=1 and all other bits 0. Decode with en=0: D=0 regardless of DI.
- The three functions are independent. en affects only D; Cin affects only S and Cout.
- Deasserting clr coincident with a rising edge: that edge does not capture. The first capture is on the next edge with load high.
- X or Z on inputs is not handled specially.

Decomposition:
- Shared package arith_decode_pkg holds:
  - the WIDTH default constant;
  - a packed struct cmp_t {lt, eq, gt} used for the compare result.
- One sub-module is natural: ripple_adder #(WIDTH), a purely combinational block with ports A, B, Cin, S, Cout.
- Compare, decode and the output register bank are written inline in the top.

Test Plan:
- Reset: assert clr with load=1 and nonzero inputs -> all outputs 0 immediately and across two clock edges.
- Basic capture: A=8'b10001000, B=8'b00001111, Cin=0, DI=3'b111, en=1, load=1, one edge -> S=8'b10010111, Cout=0, AgtB=1, AltB=0, AeqB=0, D=8'b10000000.
- Overflow and carry-in: A=8'hFF, B=8'h00, Cin=1 -> S=8'h00, Cout=1, AgtB=1. Then A=8'h7F, B=8'h80, Cin=1 -> S=8'h00, Cout=1, AltB=1.
- Equal and decoder disable: A=B=8'h55, Cin=0, DI=3'b011, en=0 -> AeqB=1, S=8'hAA, Cout=0, D=8'h00. Then en=1 -> D=8'b00001000.
- Hold: capture one set of results, then change all inputs with load=0 for 3 edges -> outputs unchanged. Raise load -> outputs update on the next edge only.
- Mid-operation reset: capture nonzero results, pulse clr between clock edges -> outputs drop to 0 asynchronously and stay 0 until the next load edge after clr falls.
